// File: rtl/mux_rr_arb_if.sv
// Handshake bundle for mux_rr_arb: N request channels in, one registered beat out.
// slave is the arbiter's view; master is the view of the producers and consumer driving it.
interface mux_rr_arb_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 8
);
  logic [N-1:0] in_valid;
  logic [W-1:0] in_data [N];
  logic [N-1:0] in_last;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [N-1:0] out_grant;
  logic         out_last;
  logic         out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_grant, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_grant, out_last
  );
endinterface

// File: rtl/mux_rr_arb.sv
// N:1 round-robin arbitrating mux with a registered output stage and one-hot grant.
// Define MUX_RR_ARB_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module mux_rr_arb #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 8
) (
  input logic           clk,
  input logic           rst,
  mux_rr_arb_if.slave   bus
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [N-1:0]  out_grant_q;
  logic          out_last_q;

  logic          load_en;
  logic [N-1:0]  grant_c;
  logic [PW-1:0] grant_idx;
  logic          xfer;
  logic [PW-1:0] ptr_next;

`ifdef MUX_RR_ARB_PKT_LOCK_EN
  typedef enum logic [0:0] {StUnlocked, StLocked} lock_state_e;
  lock_state_e   state_q;
  logic [N-1:0]  lock_ch_q;
  logic [PW-1:0] lock_idx;

  always_comb begin
    lock_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (lock_ch_q[i]) lock_idx = PW'(i);
    end
  end
`endif

  assign load_en = !out_valid_q || bus.out_ready;

  // Rotating priority search starting at ptr_q; first valid channel wins.
  always_comb begin : arb
    int unsigned idx;
    logic        found;
    grant_c   = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && bus.in_valid[PW'(idx)]) begin
        found     = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    if (found) grant_c[grant_idx] = 1'b1;
`ifdef MUX_RR_ARB_PKT_LOCK_EN
    if (state_q == StLocked) begin
      grant_c   = lock_ch_q & bus.in_valid;
      grant_idx = lock_idx;
    end
`endif
  end

  assign bus.in_ready = grant_c & {N{load_en}};
  assign xfer         = load_en && (grant_c != '0);
  assign ptr_next     = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_grant_q <= '0;
      out_last_q  <= 1'b0;
    end else if (load_en) begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in_data[grant_idx];
        out_grant_q <= grant_c;
        out_last_q  <= bus.in_last[grant_idx];
        // While locked grant_idx is the lock index, so this already lands on lock+1.
        ptr_q       <= ptr_next;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef MUX_RR_ARB_PKT_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StUnlocked;
      lock_ch_q <= '0;
    end else if (xfer) begin
      unique case (state_q)
        StUnlocked: begin
          if (!bus.in_last[grant_idx]) begin
            state_q   <= StLocked;
            lock_ch_q <= grant_c;
          end
        end
        StLocked: begin
          if (bus.in_last[grant_idx]) begin
            state_q   <= StUnlocked;
            lock_ch_q <= '0;
          end
        end
        default: state_q <= StUnlocked;
      endcase
    end
  end
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_grant = out_grant_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb with N=4, W=8; expected values are hand-derived per step.
module tb_mux_rr_arb;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mux_rr_arb_if #(.N(N), .W(W)) ifc ();

  mux_rr_arb #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data_ramp();
    for (int i = 0; i < N; i++) ifc.in_data[i] = 8'h10 + W'(i);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    ifc.in_valid  = '0;
    ifc.in_last   = '1;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < N; i++) ifc.in_data[i] = '0;
    #3;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("rst_out_data",  32'(ifc.out_data),  32'h0);
    chk("rst_out_grant", 32'(ifc.out_grant), 32'h0);
    chk("rst_out_last",  32'(ifc.out_last),  32'h0);
    chk("rst_in_ready",  32'(ifc.in_ready),  32'h0);
    tick();
    tick();
    #3 rst = 1'b0;

    // Single requester on ch2.
    tick();
    ifc.in_valid   = 4'b0100;
    ifc.in_data[2] = 8'hA5;
    #1;
    chk("single_in_ready", 32'(ifc.in_ready), 32'h4);
    tick();
    chk("single_out_valid", 32'(ifc.out_valid), 32'h1);
    chk("single_out_data",  32'(ifc.out_data),  32'hA5);
    chk("single_out_grant", 32'(ifc.out_grant), 32'h4);

    // ptr=3: all valid picks ch3; with only ch0/ch1 valid it wraps to ch0.
    set_data_ramp();
    ifc.in_valid = 4'b1111;
    #1;
    chk("ptr3_all_in_ready", 32'(ifc.in_ready), 32'h8);
    ifc.in_valid = 4'b0011;
    #1;
    chk("wrap_in_ready", 32'(ifc.in_ready), 32'h1);
    tick();
    chk("wrap_grant0", 32'(ifc.out_grant), 32'h1);
    chk("wrap_data0",  32'(ifc.out_data),  32'h10);
    chk("skip_in_ready", 32'(ifc.in_ready), 32'h2);
    tick();
    chk("skip_grant1", 32'(ifc.out_grant), 32'h2);
    chk("skip_data1",  32'(ifc.out_data),  32'h11);

    // No request: output empties, grant holds.
    ifc.in_valid = '0;
    tick();
    chk("idle_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("idle_grant_hold", 32'(ifc.out_grant), 32'h2);

    // Fairness from ptr=2: ch2,3,0,1,2,3,0,1.
    ifc.in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      int unsigned e;
      e = (2 + k) % N;
      tick();
      chk($sformatf("rr_grant_%0d", k), 32'(ifc.out_grant), 32'(1) << e);
      chk($sformatf("rr_data_%0d", k),  32'(ifc.out_data),  32'h10 + e);
      chk($sformatf("rr_valid_%0d", k), 32'(ifc.out_valid), 32'h1);
    end

    // Backpressure holding the ch1 beat (0x11).
    ifc.out_ready = 1'b0;
    #1;
    chk("bp_in_ready_now", 32'(ifc.in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_in_ready_%0d", k), 32'(ifc.in_ready), 32'h0);
      chk($sformatf("bp_data_%0d", k),     32'(ifc.out_data), 32'h11);
      chk($sformatf("bp_valid_%0d", k),    32'(ifc.out_valid), 32'h1);
    end
    ifc.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(ifc.in_ready), 32'h4);
    tick();
    chk("bp_release_data",  32'(ifc.out_data),  32'h12);
    chk("bp_release_grant", 32'(ifc.out_grant), 32'h4);

    // Async reset between edges while a beat is held.
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("arst_out_data",  32'(ifc.out_data),  32'h0);
    #1 rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(ifc.in_ready), 32'h1);
    tick();
    chk("arst_first_grant", 32'(ifc.out_grant), 32'h1);
    chk("arst_first_data",  32'(ifc.out_data),  32'h10);

`ifdef MUX_RR_ARB_PKT_LOCK_EN
    // ptr=1 now. ch1 sends a 3-beat packet with a valid gap; others stay valid.
    ifc.in_valid = 4'b1111;
    ifc.in_last  = 4'b1101;
    tick();
    chk("lock_b1_grant", 32'(ifc.out_grant), 32'h2);
    chk("lock_b1_last",  32'(ifc.out_last),  32'h0);
    tick();
    chk("lock_b2_grant", 32'(ifc.out_grant), 32'h2);
    ifc.in_valid = 4'b1101;
    #1;
    chk("lock_gap_in_ready", 32'(ifc.in_ready), 32'h0);
    tick();
    chk("lock_gap_out_valid", 32'(ifc.out_valid), 32'h0);
    ifc.in_valid = 4'b1111;
    ifc.in_last  = 4'b1111;
    tick();
    chk("lock_b3_grant", 32'(ifc.out_grant), 32'h2);
    chk("lock_b3_last",  32'(ifc.out_last),  32'h1);
    tick();
    chk("lock_after_grant", 32'(ifc.out_grant), 32'h4);
`else
    // ptr=1 now. in_last is simply registered; arbitration keeps rotating.
    ifc.in_valid = 4'b1111;
    ifc.in_last  = 4'b1101;
    tick();
    chk("last0_grant", 32'(ifc.out_grant), 32'h2);
    chk("last0_last",  32'(ifc.out_last),  32'h0);
    tick();
    chk("last1_grant", 32'(ifc.out_grant), 32'h4);
    chk("last1_last",  32'(ifc.out_last),  32'h1);
`endif

    ifc.in_valid = '0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
